fir_rd_req: RTL and testbench

- Read-request engine directly downstream of the FIR CSR block.
- Consumes the control word and input-buffer descriptor (line address, byte size) written by host MMIO.
- Walks the buffer and issues one CCI-P cache-line read per 64-byte line on c0Tx, honouring almost-full and an outstanding-request credit limit.
- Counts returning read responses and reports busy/done to the FIR datapath and status writer.

---
 rtl/fir_rd_req.sv | 154 +++++++++++++++
 tb/tb_fir_rd_req.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_rd_req.sv
// Walks the input buffer, issuing one cache-line read per line under almost-full and credit backpressure.
// Latency: first read two cycles after start is sampled. Optional perf counters: FIR_RD_REQ_PERF_EN.
module fir_rd_req #(
   parameter int ADDR_W          = 42,
   parameter int MDATA_W         = 16,
   parameter int MAX_OUTSTANDING = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        hc_control,
   input  logic [ADDR_W-1:0]  buf_addr,
   input  logic [31:0]        buf_size,
   input  logic               c0TxAlmFull,
   output logic               rd_valid,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [MDATA_W-1:0] rd_mdata,
   input  logic               rsp_valid,
   output logic               busy,
   output logic               done,
   output logic [31:0]        perf_cycles,
   output logic [31:0]        perf_stalls
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state_q;
   logic               start_q;
   logic [ADDR_W-1:0]  base_q;
   logic [26:0]        lines_q;
   logic [26:0]        issued_q, issued_d;
   logic [26:0]        returned_q, returned_d;
   logic [OUT_W-1:0]   outstanding_q, outstanding_d;
   logic               rd_valid_q, busy_q, done_q;
   logic [ADDR_W-1:0]  rd_addr_q;
   logic [MDATA_W-1:0] rd_mdata_q;
   logic               start_evt, issue_ok, rsp_ok;
   logic [32:0]        lines_sum;
   logic [26:0]        lines_new;
   logic               unused_bits;

   // Round the byte size up to whole 64-byte lines without losing the carry.
   assign lines_sum   = {1'b0, buf_size} + 33'd63;
   assign lines_new   = lines_sum[32:6];
   assign unused_bits = ^{hc_control[31:1], lines_sum[5:0]};

   always_comb begin
      start_evt     = hc_control[0] & ~start_q;
      issue_ok      = (state_q == ISSUE) & ~c0TxAlmFull &
                      (outstanding_q < MAX_OUT) & (issued_q < lines_q);
      // A response with nothing in flight is stale (e.g. after reset) and is dropped.
      rsp_ok        = rsp_valid & (state_q != IDLE) & (outstanding_q != '0);
      issued_d      = issued_q + 27'(issue_ok);
      returned_d    = returned_q + 27'(rsp_ok);
      outstanding_d = outstanding_q;
      if (issue_ok & ~rsp_ok)
         outstanding_d = outstanding_q + OUT_W'(1);
      else if (~issue_ok & rsp_ok)
         outstanding_d = outstanding_q - OUT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         start_q       <= 1'b0;
         base_q        <= '0;
         lines_q       <= '0;
         issued_q      <= '0;
         returned_q    <= '0;
         outstanding_q <= '0;
         rd_valid_q    <= 1'b0;
         rd_addr_q     <= '0;
         rd_mdata_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         start_q       <= hc_control[0];
         rd_valid_q    <= 1'b0;
         issued_q      <= issued_d;
         returned_q    <= returned_d;
         outstanding_q <= outstanding_d;
         if (issue_ok) begin
            rd_valid_q <= 1'b1;
            rd_addr_q  <= base_q + ADDR_W'(issued_q);
            rd_mdata_q <= MDATA_W'(issued_q);
         end
         case (state_q)
            IDLE: begin
               if (start_evt) begin
                  base_q        <= buf_addr;
                  lines_q       <= lines_new;
                  issued_q      <= '0;
                  returned_q    <= '0;
                  outstanding_q <= '0;
                  state_q       <= (lines_new == '0) ? DONE : ISSUE;
                  busy_q        <= (lines_new != '0);
                  done_q        <= (lines_new == '0);
               end
            end
            ISSUE: begin
               if (issued_q == lines_q)
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (returned_d == lines_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               if (!hc_control[0]) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_addr  = rd_addr_q;
   assign rd_mdata = rd_mdata_q;
   assign busy     = busy_q;
   assign done     = done_q;

`ifdef FIR_RD_REQ_PERF_EN
   logic [31:0] perf_cycles_q, perf_stalls_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else if ((state_q == IDLE) && start_evt) begin
         perf_cycles_q <= '0;
         perf_stalls_q <= '0;
      end else begin
         if (busy_q && (perf_cycles_q != '1))
            perf_cycles_q <= perf_cycles_q + 32'd1;
         if ((state_q == ISSUE) && (issued_q < lines_q) && c0TxAlmFull && (perf_stalls_q != '1))
            perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stalls = perf_stalls_q;
`else
   assign perf_cycles = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_fir_rd_req.sv
// Randomized bench for fir_rd_req against a transaction-level reference of the read walk.
module tb_fir_rd_req;
   localparam int ADDR_W  = 42;
   localparam int MDATA_W = 16;
   localparam int MAXO    = 4;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [31:0]        hc_control = '0;
   logic [ADDR_W-1:0]  buf_addr = '0;
   logic [31:0]        buf_size = '0;
   logic               c0TxAlmFull = 1'b0;
   logic               rd_valid;
   logic [ADDR_W-1:0]  rd_addr;
   logic [MDATA_W-1:0] rd_mdata;
   logic               rsp_valid = 1'b0;
   logic               busy, done;
   logic [31:0]        perf_cycles, perf_stalls;

   always #5 clk = ~clk;

   fir_rd_req #(.ADDR_W(ADDR_W), .MDATA_W(MDATA_W), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset), .hc_control(hc_control), .buf_addr(buf_addr),
      .buf_size(buf_size), .c0TxAlmFull(c0TxAlmFull), .rd_valid(rd_valid),
      .rd_addr(rd_addr), .rd_mdata(rd_mdata), .rsp_valid(rsp_valid), .busy(busy),
      .done(done), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
   );

   int checks = 0, failures = 0, cyc = 0;

   // Stimulus commands applied each cycle
   bit                hc_cmd, alm_force, rsp_man;
   int                alm_pct, rsp_mode, rsp_delay;
   logic [ADDR_W-1:0] addr_cmd;
   logic [31:0]       size_cmd;

   // Reference model state
   bit                m_active, m_drain, m_hc_prev, exp_vld, exp_busy, exp_done;
   logic [ADDR_W-1:0] m_base;
   longint            m_lines, m_next, m_ret, m_out;
   int                m_busy_cnt, m_stall_cnt;
   int                rsp_due[$];
   int                obs_reqs, first_req_cyc, last_req_cyc;

   task automatic reset_model();
      m_active = 0; m_drain = 0; m_hc_prev = 0;
      exp_vld = 0; exp_busy = 0; exp_done = 0;
      m_base = '0; m_lines = 0; m_next = 0; m_ret = 0; m_out = 0;
      m_busy_cnt = 0; m_stall_cnt = 0;
      rsp_due.delete();
      hc_cmd = 0; alm_force = 0; rsp_man = 0; alm_pct = 0; rsp_mode = 0; rsp_delay = 0;
   endtask

   // One clock: observe outputs #1 after the edge, compare, then drive and advance the model.
   task automatic cycle();
      logic [ADDR_W-1:0]  ea;
      logic [MDATA_W-1:0] em;
      bit                 alm, rsp, sevt;
      longint             out_pre;
      @(posedge clk); #1; cyc++;
      checks++;
      if (rd_valid !== exp_vld) begin
         failures++;
         $display("FAIL rd_valid cyc=%0d got=%0b exp=%0b", cyc, rd_valid, exp_vld);
      end
      if (exp_vld) begin
         ea = m_base + ADDR_W'(m_next);
         em = MDATA_W'(m_next);
         checks++;
         if (rd_addr !== ea || rd_mdata !== em) begin
            failures++;
            $display("FAIL rd_req cyc=%0d got=%h/%0d exp=%h/%0d", cyc, rd_addr, rd_mdata, ea, em);
         end
         m_next++; m_out++;
         if (rsp_mode == 1) rsp_due.push_back(cyc + rsp_delay);
      end
      if (rd_valid === 1'b1) begin
         obs_reqs++;
         if (first_req_cyc < 0) first_req_cyc = cyc;
         last_req_cyc = cyc;
      end
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
         failures++;
         $display("FAIL status cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                  cyc, busy, done, exp_busy, exp_done);
      end
      if (exp_busy) m_busy_cnt++;

      alm = alm_force || (alm_pct > 0 && $urandom_range(0, 99) < alm_pct);
      rsp = rsp_man; rsp_man = 0;
      while (rsp_due.size() > 0 && rsp_due[0] < cyc) void'(rsp_due.pop_front());
      if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin rsp = 1; void'(rsp_due.pop_front()); end
      if (rsp_mode == 2) rsp = ($urandom_range(0, 2) == 0);
      c0TxAlmFull = alm;
      rsp_valid   = rsp;
      hc_control  = {31'h0, hc_cmd};
      buf_addr    = addr_cmd;
      buf_size    = size_cmd;

      // A line is requested next cycle iff transfer is issuing, not throttled, has credit, lines remain.
      out_pre = m_out;
      exp_vld = exp_busy && !alm && out_pre < MAXO && m_next < m_lines;
      if (exp_busy && m_next < m_lines && alm) m_stall_cnt++;
      if (rsp && m_active && m_out > 0) begin m_out--; m_ret++; end
      sevt = hc_cmd && !m_hc_prev;
      m_hc_prev = hc_cmd;
      if (!m_active) begin
         if (sevt) begin
            m_base = addr_cmd;
            m_lines = (longint'(size_cmd) + 63) / 64;
            m_next = 0; m_ret = 0; m_out = 0; m_drain = 0;
            m_busy_cnt = 0; m_stall_cnt = 0;
            m_active = 1;
            exp_busy = (m_lines != 0);
            exp_done = (m_lines == 0);
         end
      end else if (exp_done) begin
         if (!hc_cmd) begin exp_done = 0; m_active = 0; end
      end else if (m_drain && m_ret == m_lines) begin
         exp_done = 1; exp_busy = 0; m_drain = 0;
      end else if (m_next == m_lines) begin
         m_drain = 1;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      hc_control = '0; buf_addr = '0; buf_size = '0; c0TxAlmFull = 0; rsp_valid = 0;
      #2;
      checks++;
      if ({rd_valid, rd_addr, rd_mdata, busy, done, perf_cycles, perf_stalls} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got vld=%b addr=%h md=%h busy=%b done=%b pc=%0d ps=%0d exp all 0",
                  rd_valid, rd_addr, rd_mdata, busy, done, perf_cycles, perf_stalls);
      end
      reset_model();
      addr_cmd = '0; size_cmd = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [31:0] s,
                             input int mode, input int dly, input int pct);
      addr_cmd = a; size_cmd = s; rsp_mode = mode; rsp_delay = dly; alm_pct = pct;
      obs_reqs = 0; first_req_cyc = -1; last_req_cyc = -1;
      hc_cmd = 1;
   endtask

   task automatic finish_xfer(input longint exp_lines, input bit drop);
      bit seen = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (done === 1'b1) begin seen = 1; break; end
      end
      checks++;
      if (!seen) begin failures++; $display("FAIL done_timeout got done=%b exp 1", done); end
      checks++;
      if (obs_reqs != exp_lines) begin
         failures++; $display("FAIL req_count got=%0d exp=%0d", obs_reqs, exp_lines);
      end
      checks++;
`ifdef FIR_RD_REQ_PERF_EN
      if (perf_cycles !== 32'(m_busy_cnt) || perf_stalls !== 32'(m_stall_cnt)) begin
         failures++;
         $display("FAIL perf got=%0d/%0d exp=%0d/%0d", perf_cycles, perf_stalls, m_busy_cnt, m_stall_cnt);
      end
`else
      if (perf_cycles !== 32'd0 || perf_stalls !== 32'd0) begin
         failures++; $display("FAIL perf_tied got=%0d/%0d exp=0/0", perf_cycles, perf_stalls);
      end
`endif
      if (drop) begin
         hc_cmd = 0;
         cycle(); cycle();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL back_to_idle got busy=%b done=%b exp 0/0", busy, done);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      repeat (3) cycle();
   endtask

   task automatic test_basic();
      start_xfer(42'h1000, 32'd256, 1, 5, 0);
      cycle(); cycle();
      checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL first_cycle got vld=%b busy=%b exp 0/1", rd_valid, busy);
      end
      cycle();
      checks++;
      if (rd_valid !== 1'b1 || rd_addr !== 42'h1000 || rd_mdata !== 16'd0) begin
         failures++; $display("FAIL first_req got vld=%b addr=%h exp 1/1000", rd_valid, rd_addr);
      end
      finish_xfer(4, 1);
   endtask

   task automatic test_sizes();
      start_xfer(42'h1000, 32'd100, 1, 3, 0);
      finish_xfer(2, 1);
      start_xfer(42'h1000, 32'd0, 1, 3, 0);
      cycle(); cycle(); cycle();
      checks++;
      if (done !== 1'b1 || obs_reqs != 0) begin
         failures++; $display("FAIL zero_size got done=%b reqs=%0d exp 1/0", done, obs_reqs);
      end
      finish_xfer(0, 1);
   endtask

   task automatic test_credit();
      start_xfer(42'h2000, 32'd640, 0, 0, 0);
      repeat (20) cycle();
      checks++;
      if (obs_reqs != MAXO) begin
         failures++; $display("FAIL credit_stall got=%0d exp=%0d", obs_reqs, MAXO);
      end
      rsp_man = 1;
      repeat (10) cycle();
      checks++;
      if (obs_reqs != MAXO + 1) begin
         failures++; $display("FAIL credit_one got=%0d exp=%0d", obs_reqs, MAXO + 1);
      end
      rsp_mode = 2;
      finish_xfer(10, 1);
   endtask

   task automatic test_almfull();
      int n0;
      start_xfer(42'h4000, 32'd1280, 1, 2, 0);
      for (int i = 0; i < 50 && obs_reqs < 5; i++) cycle();
      alm_force = 1;
      cycle();
      n0 = obs_reqs;
      repeat (9) cycle();
      alm_force = 0;
      cycle();
      checks++;
      if (obs_reqs != n0) begin
         failures++; $display("FAIL almfull_hold got=%0d exp=%0d", obs_reqs, n0);
      end
`ifdef FIR_RD_REQ_PERF_EN
      checks++;
      if (perf_stalls !== 32'd10) begin
         failures++; $display("FAIL perf_stalls got=%0d exp=10", perf_stalls);
      end
`endif
      finish_xfer(20, 1);
   endtask

   task automatic test_back_to_back();
      start_xfer(42'h5000, 32'd768, 1, 2, 0);
      finish_xfer(12, 1);
      checks++;
      if (last_req_cyc - first_req_cyc != 11) begin
         failures++; $display("FAIL same_cycle_span got=%0d exp=11", last_req_cyc - first_req_cyc);
      end
   endtask

   task automatic test_hold_start();
      start_xfer(42'h6000, 32'd128, 1, 1, 0);
      finish_xfer(2, 0);
      repeat (10) cycle();
      checks++;
      if (done !== 1'b1 || obs_reqs != 2) begin
         failures++; $display("FAIL no_restart got done=%b reqs=%0d exp 1/2", done, obs_reqs);
      end
      hc_cmd = 0;
      cycle(); cycle();
      start_xfer(42'h7000, 32'd192, 1, 4, 0);
      finish_xfer(3, 1);
   endtask

   task automatic test_reset_mid();
      start_xfer(42'h3000, 32'd512, 0, 0, 0);
      for (int i = 0; i < 30 && obs_reqs < 3; i++) cycle();
      apply_reset();
      repeat (3) begin rsp_man = 1; cycle(); end
      repeat (10) cycle();
      checks++;
      if (obs_reqs != 3 || {rd_valid, rd_addr, rd_mdata, busy, done, perf_cycles, perf_stalls} !== '0) begin
         failures++;
         $display("FAIL reset_mid got reqs=%0d vld=%b addr=%h busy=%b done=%b pc=%0d exp 3 and all 0",
                  obs_reqs, rd_valid, rd_addr, busy, done, perf_cycles);
      end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      logic [31:0]       s;
      for (int i = 0; i < 15; i++) begin
         a = ADDR_W'({$urandom, $urandom});
         if (i == 0) begin a = '1; a = a - 42'd2; end
         s = 32'($urandom_range(0, 1200));
         start_xfer(a, s, $urandom_range(1, 2), $urandom_range(1, 8), $urandom_range(0, 40));
         cycle(); cycle();
         // Descriptor changes after the start event must not matter.
         addr_cmd = ADDR_W'({$urandom, $urandom});
         size_cmd = $urandom;
         finish_xfer((longint'(s) + 63) / 64, 1);
      end
   endtask

   initial begin
      reset_model();
      addr_cmd = '0; size_cmd = '0;
      obs_reqs = 0; first_req_cyc = -1; last_req_cyc = -1;
      test_reset();
      test_basic();
      test_sizes();
      test_credit();
      test_almfull();
      test_back_to_back();
      test_hold_start();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
